// File: rtl/uart_tx_mmio_if.sv
// uart_tx_mmio_if: chip-select data bus between the CPU and the UART
// transmitter.
interface uart_tx_mmio_if;
    logic        uart_sel;
    logic [15:0] uart_addr;
    logic        uart_write;
    logic [3:0]  uart_be;
    logic [31:0] uart_wdata;
    logic [31:0] uart_rdata;

    modport master (
        output uart_sel, uart_addr, uart_write, uart_be, uart_wdata,
        input  uart_rdata
    );

    modport slave (
        input  uart_sel, uart_addr, uart_write, uart_be, uart_wdata,
        output uart_rdata
    );
endinterface

// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio: memory-mapped UART transmitter, 8N1 with a TX FIFO.
// Define UART_TX_PARITY_EN for 8E1 frames (even parity bit before stop).
module uart_tx_mmio #(
    parameter int CLOCK_FREQ = 125_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int FIFO_DEPTH = 8
) (
    input  logic          clk,
    input  logic          reset,
    uart_tx_mmio_if.slave bus,
    output logic          txd
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [15:0] DIV_RST = 16'(CLOCK_FREQ / BAUD_RATE - 1);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(FIFO_DEPTH);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_STOP  = 3'd3;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] S_PAR   = 3'd4;
    logic          parity;
`endif

    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   fifo_cnt;
    logic [3:0]    cnt4;
    logic          full, empty, overflow, busy;
    logic [15:0]   baud_div, bit_cnt;
    logic [2:0]    state, bit_idx;
    logic [7:0]    shreg, fifo_q;
    logic          bit_end, pop, push_req, push, ovf_clr, wr_en;
    logic [1:0]    reg_sel;
    logic          unused_bits;

    assign reg_sel  = bus.uart_addr[3:2];
    assign wr_en    = bus.uart_sel & bus.uart_write;
    assign full     = (fifo_cnt == FULL_CNT);
    assign empty    = (fifo_cnt == '0);
    assign busy     = (state != S_IDLE);
    assign cnt4     = 4'(fifo_cnt);
    assign fifo_q   = fifo_mem[rd_ptr];
    assign bit_end  = (bit_cnt == '0);
    assign pop      = ~empty & ((state == S_IDLE) |
                                ((state == S_STOP) & bit_end));
    assign push_req = wr_en & (reg_sel == 2'd0) & bus.uart_be[0];
    // A pop in the same cycle frees a slot for a push into a full FIFO.
    assign push     = push_req & (~full | pop);
    assign ovf_clr  = wr_en & (reg_sel == 2'd1) & bus.uart_be[0] &
                      bus.uart_wdata[3];

    assign unused_bits = ^{bus.uart_addr[15:4], bus.uart_addr[1:0],
                           bus.uart_wdata[31:16], bus.uart_be[3:2]};

    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr] <= bus.uart_wdata[7:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            overflow <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            fifo_cnt <= fifo_cnt + (AW + 1)'(push) - (AW + 1)'(pop);
            if (push_req & ~push)
                overflow <= 1'b1;
            else if (ovf_clr)
                overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            baud_div <= DIV_RST;
        end else if (wr_en && reg_sel == 2'd2) begin
            if (bus.uart_be[0])
                baud_div[7:0] <= bus.uart_wdata[7:0];
            if (bus.uart_be[1])
                baud_div[15:8] <= bus.uart_wdata[15:8];
        end
    end

    // The divisor is sampled only at bit boundaries, never mid-bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            txd     <= 1'b1;
            bit_cnt <= '0;
            bit_idx <= '0;
            shreg   <= '0;
`ifdef UART_TX_PARITY_EN
            parity  <= 1'b0;
`endif
        end else begin
            if (!bit_end)
                bit_cnt <= bit_cnt - 1'b1;
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        shreg   <= fifo_q;
                        txd     <= 1'b0;
                        bit_cnt <= baud_div;
                        state   <= S_START;
                    end
                end
                S_START: begin
                    if (bit_end) begin
                        txd     <= shreg[0];
                        shreg   <= {1'b0, shreg[7:1]};
                        bit_idx <= '0;
                        bit_cnt <= baud_div;
                        state   <= S_DATA;
`ifdef UART_TX_PARITY_EN
                        parity  <= ^shreg;
`endif
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        bit_cnt <= baud_div;
                        if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            txd   <= parity;
                            state <= S_PAR;
`else
                            txd   <= 1'b1;
                            state <= S_STOP;
`endif
                        end else begin
                            txd     <= shreg[0];
                            shreg   <= {1'b0, shreg[7:1]};
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                S_PAR: begin
                    if (bit_end) begin
                        txd     <= 1'b1;
                        bit_cnt <= baud_div;
                        state   <= S_STOP;
                    end
                end
`endif
                S_STOP: begin
                    if (bit_end) begin
                        if (pop) begin
                            shreg   <= fifo_q;
                            txd     <= 1'b0;
                            bit_cnt <= baud_div;
                            state   <= S_START;
                        end else begin
                            state   <= S_IDLE;
                        end
                    end
                end
                default: begin
                    txd   <= 1'b1;
                    state <= S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        bus.uart_rdata = '0;
        if (bus.uart_sel) begin
            case (reg_sel)
                2'd1:    bus.uart_rdata[7:0] =
                             {cnt4, overflow, empty, full, busy};
                2'd2:    bus.uart_rdata[15:0] = baud_div;
                default: bus.uart_rdata = '0;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_mmio.sv
// tb_uart_tx_mmio: randomized and directed checks of the UART TX line
// against a frame-level model of the serial waveform and status.
module tb_uart_tx_mmio;
    logic clk = 1'b0;
    logic reset;
    logic txd;

    uart_tx_mmio_if bus();

    uart_tx_mmio dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .txd   (txd)
    );

    always #5 clk = ~clk;

    localparam int DIV_RST = 125_000_000 / 115_200 - 1;
    localparam logic [15:0] A_TX = 16'h0;
    localparam logic [15:0] A_ST = 16'h4;
    localparam logic [15:0] A_BD = 16'h8;
`ifdef UART_TX_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif
    localparam int FB = PAR ? 11 : 10;

    typedef bit bitq_t[$];
    typedef logic [7:0] byteq_t[$];

    int tests = 0;
    int failed = 0;
    int cyc = 0;
    logic line_log [0:32767];

    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        if (cyc < 32768)
            line_log[cyc] = txd;
    end

    // Expected line level per clock: each frame bit held for div+1 clocks.
    function automatic bitq_t build_wave(byteq_t data, int div, int pad);
        bitq_t w;
        bit fb[$];
        foreach (data[k]) begin
            fb = {1'b0};
            for (int i = 0; i < 8; i++)
                fb.push_back(data[k][i]);
            if (PAR)
                fb.push_back(^data[k]);
            fb.push_back(1'b1);
            foreach (fb[j])
                repeat (div + 1) w.push_back(fb[j]);
        end
        repeat (pad) w.push_back(1'b1);
        return w;
    endfunction

    function automatic logic [31:0] status_of(int cnt, bit ovf, bit bsy);
        return 32'((cnt << 4) | (ovf ? 8 : 0) | (cnt == 0 ? 4 : 0) |
                   (cnt == 8 ? 2 : 0) | (bsy ? 1 : 0));
    endfunction

    task automatic bus_write(input logic [15:0] addr,
                             input logic [31:0] wdata,
                             input logic [3:0] be, output int e);
        @(negedge clk);
        bus.uart_sel   = 1'b1;
        bus.uart_write = 1'b1;
        bus.uart_addr  = addr;
        bus.uart_be    = be;
        bus.uart_wdata = wdata;
        @(posedge clk);
        #1;
        e = cyc;
        bus.uart_sel   = 1'b0;
        bus.uart_write = 1'b0;
    endtask

    task automatic bus_read(input logic [15:0] addr,
                            output logic [31:0] d);
        @(negedge clk);
        bus.uart_sel   = 1'b1;
        bus.uart_write = 1'b0;
        bus.uart_addr  = addr;
        #1;
        d = bus.uart_rdata;
        bus.uart_sel = 1'b0;
    endtask

    task automatic wait_cyc(input int k);
        while (cyc < k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        tests++;
        if (txd !== 1'b1) begin
            failed++;
            $display("FAIL reset_txd: got %b want 1", txd);
        end
        bus_read(A_ST, rd);
        tests++;
        if (rd !== 32'h4) begin
            failed++;
            $display("FAIL reset_status: got %h want 00000004", rd);
        end
        bus_read(A_BD, rd);
        tests++;
        if (rd !== 32'(DIV_RST)) begin
            failed++;
            $display("FAIL reset_baud: got %0d want %0d", rd, DIV_RST);
        end
    endtask

    task automatic test_regs();
        logic [31:0] rd;
        logic [15:0] m;
        int e;
        m = 16'(DIV_RST);
        bus_write(A_BD, 32'hFFFF_ABCD, 4'b0001, e);
        m[7:0] = 8'hCD;
        bus_read(A_BD, rd);
        tests++;
        if (rd !== {16'h0, m}) begin
            failed++;
            $display("FAIL baud_lane0: got %h want %h", rd, {16'h0, m});
        end
        bus_write(A_BD, 32'h0000_1200, 4'b0010, e);
        m[15:8] = 8'h12;
        bus_read(16'h1008, rd);
        tests++;
        if (rd !== {16'h0, m}) begin
            failed++;
            $display("FAIL baud_lane1: got %h want %h", rd, {16'h0, m});
        end
        bus_write(16'hC, 32'hFFFF_FFFF, 4'b1111, e);
        bus_read(16'hC, rd);
        tests++;
        if (rd !== 32'h0) begin
            failed++;
            $display("FAIL reg3_read: got %h want 0", rd);
        end
        bus_read(A_TX, rd);
        tests++;
        if (rd !== 32'h0) begin
            failed++;
            $display("FAIL txdata_read: got %h want 0", rd);
        end
        @(negedge clk);
        bus.uart_sel  = 1'b0;
        bus.uart_addr = A_BD;
        #1;
        tests++;
        if (bus.uart_rdata !== 32'h0) begin
            failed++;
            $display("FAIL unsel_read: got %h want 0", bus.uart_rdata);
        end
    endtask

    task automatic test_basic_frame();
        logic [31:0] rd;
        bitq_t w;
        int e, nerr, first;
        bus_write(A_BD, 32'd3, 4'b0011, e);
        bus_write(A_TX, 32'h55, 4'b0001, e);
        bus_read(A_ST, rd);
        tests++;
        if (rd !== status_of(1, 0, 0)) begin
            failed++;
            $display("FAIL basic_queued: got %h want %h", rd,
                     status_of(1, 0, 0));
        end
        wait_cyc(e + 40);
        bus_read(A_ST, rd);
        tests++;
        if (rd !== status_of(0, 0, 1)) begin
            failed++;
            $display("FAIL basic_busy_end: got %h want %h", rd,
                     status_of(0, 0, 1));
        end
        bus_read(A_ST, rd);
        tests++;
        if (rd !== status_of(0, 0, 0)) begin
            failed++;
            $display("FAIL basic_idle: got %h want %h", rd,
                     status_of(0, 0, 0));
        end
        w = build_wave('{8'h55}, 3, 5);
        wait_cyc(e + w.size() + 1);
        tests++;
        if (line_log[e] !== 1'b1 || line_log[e + 1] !== 1'b0) begin
            failed++;
            $display("FAIL basic_fall: got %b%b want 10",
                     line_log[e], line_log[e + 1]);
        end
        nerr = 0;
        first = -1;
        foreach (w[i])
            if (line_log[e + 1 + i] !== w[i]) begin
                if (first < 0) first = i;
                nerr++;
            end
        tests++;
        if (nerr != 0) begin
            failed++;
            $display("FAIL basic_wave: %0d bad, first +%0d got %b want %b",
                     nerr, first + 1, line_log[e + 1 + first], w[first]);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd;
        bitq_t w;
        int e, e2, nerr, first;
        bus_write(A_BD, 32'd0, 4'b0011, e);
        bus_write(A_TX, 32'hA5, 4'b0001, e);
        bus_write(A_TX, 32'h3C, 4'b0001, e2);
        tests++;
        if (e2 !== e + 1) begin
            failed++;
            $display("FAIL b2b_edges: got %0d want %0d", e2, e + 1);
        end
        w = build_wave('{8'hA5, 8'h3C}, 0, 4);
        wait_cyc(e + w.size() + 1);
        nerr = 0;
        first = -1;
        foreach (w[i])
            if (line_log[e + 1 + i] !== w[i]) begin
                if (first < 0) first = i;
                nerr++;
            end
        tests++;
        if (nerr != 0) begin
            failed++;
            $display("FAIL b2b_wave: %0d bad, first +%0d got %b want %b",
                     nerr, first + 1, line_log[e + 1 + first], w[first]);
        end
        bus_read(A_ST, rd);
        tests++;
        if (rd !== status_of(0, 0, 0)) begin
            failed++;
            $display("FAIL b2b_idle: got %h want %h", rd,
                     status_of(0, 0, 0));
        end
    endtask

    task automatic test_overflow();
        logic [31:0] rd;
        byteq_t sent;
        bitq_t w;
        logic [7:0] b;
        int e, e0, nerr, first;
        bus_write(A_BD, 32'd7, 4'b0011, e);
        for (int k = 0; k < 10; k++) begin
            b = 8'($urandom);
            bus_write(A_TX, {24'hFFFFFF, b}, 4'b0001, e);
            if (k == 0) e0 = e;
            // One byte leaves at once, eight fill the FIFO, the tenth drops.
            if (k < 9) sent.push_back(b);
        end
        bus_read(A_ST, rd);
        tests++;
        if (rd !== status_of(8, 1, 1)) begin
            failed++;
            $display("FAIL ovf_status: got %h want %h", rd,
                     status_of(8, 1, 1));
        end
        bus_write(A_ST, 32'h8, 4'b0001, e);
        bus_read(A_ST, rd);
        tests++;
        if (rd !== status_of(8, 0, 1)) begin
            failed++;
            $display("FAIL ovf_clear: got %h want %h", rd,
                     status_of(8, 0, 1));
        end
        w = build_wave(sent, 7, 20);
        wait_cyc(e0 + w.size() + 1);
        nerr = 0;
        first = -1;
        foreach (w[i])
            if (line_log[e0 + 1 + i] !== w[i]) begin
                if (first < 0) first = i;
                nerr++;
            end
        tests++;
        if (nerr != 0) begin
            failed++;
            $display("FAIL ovf_wave: %0d bad, first +%0d got %b want %b",
                     nerr, first + 1, line_log[e0 + 1 + first], w[first]);
        end
        bus_read(A_ST, rd);
        tests++;
        if (rd !== status_of(0, 0, 0)) begin
            failed++;
            $display("FAIL ovf_drain: got %h want %h", rd,
                     status_of(0, 0, 0));
        end
    endtask

    task automatic test_reset_midframe();
        logic [31:0] rd;
        logic [7:0] rb [2];
        int e, e2, c, nerr;
        rb[0] = 8'hFF;
        rb[1] = 8'h00;
        foreach (rb[r]) begin
            bus_write(A_BD, 32'd15, 4'b0011, e);
            bus_write(A_TX, {24'h0, rb[r]}, 4'b0001, e);
            bus_write(A_TX, 32'h12, 4'b0001, e2);
            wait_cyc(e + 72);
            @(negedge clk);
            reset = 1'b1;
            #1;
            tests++;
            if (txd !== 1'b1) begin
                failed++;
                $display("FAIL rst_async_txd[%0d]: got %b want 1", r, txd);
            end
            repeat (2) @(posedge clk);
            @(negedge clk);
            reset = 1'b0;
            bus_read(A_ST, rd);
            tests++;
            if (rd !== 32'h4) begin
                failed++;
                $display("FAIL rst_status[%0d]: got %h want 00000004",
                         r, rd);
            end
            bus_read(A_BD, rd);
            tests++;
            if (rd !== 32'(DIV_RST)) begin
                failed++;
                $display("FAIL rst_baud[%0d]: got %0d want %0d",
                         r, rd, DIV_RST);
            end
            c = cyc;
            wait_cyc(c + 101);
            nerr = 0;
            for (int i = 1; i <= 100; i++)
                if (line_log[c + i] !== 1'b1) nerr++;
            tests++;
            if (nerr != 0) begin
                failed++;
                $display("FAIL rst_quiet[%0d]: %0d low samples want 0",
                         r, nerr);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] rd;
        byteq_t sent;
        bitq_t w;
        int e, e0, div, n, nerr, first;
        for (int it = 0; it < 6; it++) begin
            div = $urandom_range(0, 4);
            n = $urandom_range(1, 4);
            sent = {};
            bus_write(A_BD, 32'(div), 4'b0011, e);
            for (int k = 0; k < n; k++) begin
                sent.push_back(8'($urandom));
                bus_write(A_TX, {24'h0, sent[k]}, 4'b0001, e);
                if (k == 0) e0 = e;
            end
            w = build_wave(sent, div, 3);
            wait_cyc(e0 + w.size() + 1);
            nerr = 0;
            first = -1;
            foreach (w[i])
                if (line_log[e0 + 1 + i] !== w[i]) begin
                    if (first < 0) first = i;
                    nerr++;
                end
            tests++;
            if (nerr != 0) begin
                failed++;
                $display("FAIL rand_wave[%0d] div=%0d n=%0d: %0d bad, first +%0d got %b want %b",
                         it, div, n, nerr, first + 1,
                         line_log[e0 + 1 + first], w[first]);
            end
            bus_read(A_ST, rd);
            tests++;
            if (rd !== status_of(0, 0, 0)) begin
                failed++;
                $display("FAIL rand_idle[%0d]: got %h want %h", it, rd,
                         status_of(0, 0, 0));
            end
        end
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        logic [7:0] pb [2];
        bitq_t w;
        int e, nerr;
        pb[0] = 8'h07;
        pb[1] = 8'h03;
        bus_write(A_BD, 32'd1, 4'b0011, e);
        foreach (pb[r]) begin
            bus_write(A_TX, {24'h0, pb[r]}, 4'b0001, e);
            w = build_wave('{pb[r]}, 1, 4);
            wait_cyc(e + w.size() + 1);
            tests++;
            if (line_log[e + 19] !== ^pb[r] || line_log[e + 20] !== ^pb[r]) begin
                failed++;
                $display("FAIL par_bit[%0d]: got %b%b want %b", r,
                         line_log[e + 19], line_log[e + 20], ^pb[r]);
            end
            nerr = 0;
            foreach (w[i])
                if (line_log[e + 1 + i] !== w[i]) nerr++;
            tests++;
            if (nerr != 0) begin
                failed++;
                $display("FAIL par_wave[%0d]: %0d bad samples want 0",
                         r, nerr);
            end
        end
    endtask
`endif

    initial begin
        reset          = 1'b1;
        bus.uart_sel   = 1'b0;
        bus.uart_write = 1'b0;
        bus.uart_addr  = '0;
        bus.uart_be    = '0;
        bus.uart_wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        test_reset();
        test_regs();
        test_basic_frame();
        test_back_to_back();
        test_overflow();
        test_reset_midframe();
        test_random();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
